dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Blocking, direct-mapped, write-through / no-write-allocate data cache between the MEM stage and
//  external memory. Generates stall_cache, which holds IF/ID, ID/EX, EX/MEM and MEM/WB in place on a miss or write.
//  The pipeline re-presents the held request every cycle while stall_cache=1.
// PARAMETERS
//  LINES      16  number of cache lines (power of 2, >=2)
//  WORDS      4   32-bit words per line (power of 2, >=2)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  cpu_req      in   1   MEM-stage load/store valid
//  cpu_we       in   1   1=store, 0=load
//  cpu_addr     in   32  byte address, word-aligned ([1:0] ignored)
//  cpu_wdata    in   32  store data
//  cpu_rdata    out  32  load data, valid when cpu_req & !cpu_we & !stall_cache
//  stall_cache  out  1   pipeline hold request
//  mem_req      out  1   memory request, held until mem_valid
//  mem_we       out  1   1=write beat, 0=read beat
//  mem_addr     out  32  word-aligned memory address
//  mem_wdata    out  32  write data
//  mem_rdata    in   32  read data, sampled when mem_valid
//  mem_valid    in   1   one-cycle beat completion
// BEHAVIOUR
//  Address split: off=[1:0] ignored; word=[2+:log2(WORDS)]; index=next log2(LINES) bits; tag=remaining bits.
//  Storage: data[LINES][WORDS], tag[LINES], valid[LINES]. hit = valid[idx] & tag[idx]==tag(cpu_addr).
//  Reset (async, rst_n=0): all valid=0, state=IDLE, beat=0, stall_cache=0, mem_req=0, mem_we=0,
//    mem_addr=0, mem_wdata=0, cpu_rdata=0. Data/tag arrays are not reset.
//  FSM states: IDLE, REFILL, WRITE, WDONE.
//  IDLE:
//    - no cpu_req: stall_cache=0, no memory activity.
//    - load hit: cpu_rdata=data[idx][word] combinationally in the same cycle; stall_cache=0.
//    - load miss: stall_cache=1 in the same cycle. Latch the line base address; beat=0; ->REFILL.
//    - store (hit or miss): stall_cache=1 in the same cycle. Latch addr/wdata; ->WRITE.
//  REFILL: mem_req=1, mem_we=0, mem_addr=line_base+4*beat, stall_cache=1.
//    On mem_valid: data[idx][beat]=mem_rdata; beat++.
//    On the last beat: tag/valid[idx] set; ->IDLE. The held load then hits next cycle, so stall drops then.
//    Miss latency = WORDS beats + 1 cycle.
//  WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values, stall_cache=1.
//    On mem_valid: if the line holds the same tag and is valid, update data[idx][word] (no allocate on miss); ->WDONE.
//  WDONE: stall_cache=0 for one cycle, so the pipeline advances past the held store.
//    The re-presented store is consumed, not rewritten. ->IDLE.
//  mem_req stays asserted with stable addr/we/wdata until mem_valid; mem_valid outside REFILL/WRITE is ignored.
//  cpu_req/cpu_addr changes while stall_cache=1 are ignored; the latched request is used.
//  Refill overwrites the line unconditionally (write-through, no dirty state).
//  rst_n low mid-REFILL/WRITE: abort immediately to reset state.
//    The partially filled line stays invalid; the memory beat in flight is dropped.
// TESTING
//  1 Reset, load 0x100 (cold) -> stall_cache=1 at once, 4 read beats at 0x100,0x104,0x108,0x10C,
//    stall drops 1 cycle after the last beat, cpu_rdata=mem[0x100].
//  2 After 1, load 0x10C -> stall_cache=0, same-cycle cpu_rdata=mem[0x10C], no mem_req.
//  3 Store 0xDEADBEEF to 0x104 (hit) -> one write beat at 0x104, one WDONE cycle with stall=0;
//    then load 0x104 hits with 0xDEADBEEF.
//  4 Store to 0x2000 (miss) -> write beat only, no refill; later load 0x2000 misses and refills.
//  5 Conflict: load 0x100, then 0x500 (same index, LINES=16, WORDS=4) -> 0x500 refills and evicts;
//    reloading 0x100 misses again.
//  6 Assert rst_n=0 during beat 2 of a refill -> outputs at reset values in the same cycle;
//    after release, load of that line misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through data cache: load hits return data in the same cycle, and a load miss takes WORDS beats plus 1 cycle.
// Load misses and all stores hold stall_cache until their memory beats complete; mem_req holds stable until mem_valid.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - WB - IB;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;
  state_t state, state_nxt;

  logic [31:0]      data_q [LINES][WORDS];
  logic [TB-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [29:0]      req_waddr;
  logic [31:0]      req_wdata;
  logic [WB-1:0]    beat;

  logic [WB-1:0] c_word, r_word;
  logic [IB-1:0] c_idx, r_idx;
  logic [TB-1:0] c_tag, r_tag;
  logic          c_hit, r_hit, last_beat, unused_off;

  assign c_word     = cpu_addr[2 +: WB];
  assign c_idx      = cpu_addr[2+WB +: IB];
  assign c_tag      = cpu_addr[31 -: TB];
  assign r_word     = req_waddr[0 +: WB];
  assign r_idx      = req_waddr[WB +: IB];
  assign r_tag      = req_waddr[29 -: TB];
  assign c_hit      = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign last_beat  = (beat == WB'(WORDS - 1));
  assign unused_off = ^cpu_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cpu_req && cpu_we)      state_nxt = WRITE;
        else if (cpu_req && !c_hit) state_nxt = REFILL;
      end
      REFILL:  if (mem_valid && last_beat) state_nxt = IDLE;
      WRITE:   if (mem_valid) state_nxt = WDONE;
      WDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so a held pipeline request cannot raise stall during reset.
  always_comb begin
    stall_cache = 1'b0;
    cpu_rdata   = 32'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          stall_cache = cpu_req && (cpu_we || !c_hit);
          if (cpu_req && !cpu_we && c_hit) cpu_rdata = data_q[c_idx][c_word];
        end
        REFILL: begin
          stall_cache = 1'b1;
          mem_req     = 1'b1;
          mem_addr    = {req_waddr[29:WB], beat, 2'b00};
        end
        WRITE: begin
          stall_cache = 1'b1;
          mem_req     = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = {req_waddr, 2'b00};
          mem_wdata   = req_wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      req_waddr <= '0;
      req_wdata <= '0;
      beat      <= '0;
    end else begin
      if (state == IDLE && cpu_req && (cpu_we || !c_hit)) begin
        req_waddr <= cpu_addr[31:2];
        beat      <= '0;
        if (cpu_we) req_wdata <= cpu_wdata;
        else        valid_q[c_idx] <= 1'b0;
      end
      if (state == REFILL && mem_valid) begin
        beat <= beat + 1'b1;
        if (last_beat) valid_q[r_idx] <= 1'b1;
      end
    end
  end

  // The refill always overwrites the line. A store updates the line only when the store's line is resident.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_valid) begin
      data_q[r_idx][beat] <= mem_rdata;
      if (last_beat) tag_q[r_idx] <= r_tag;
    end else if (state == WRITE && mem_valid && r_hit) begin
      data_q[r_idx][r_word] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Random plus directed bench for dcache_ctrl: a memory image and a per-index resident-line map predict stalls, beats and load data.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0, cpu_rdata;
  logic        stall_cache, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_valid = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall_cache(stall_cache), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  int          total = 0, bad = 0;
  bit          fast;
  int          stall_cnt;
  logic [31:0] last_rdata;
  logic [31:0] mem_m [bit [31:0]];
  bit   [31:0] res_base [16];
  bit          res_v [16];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_cache}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
  endtask

  task automatic drive_phase;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_rdata = $urandom;
  endtask

  // An unsolicited mem_valid outside REFILL/WRITE must be ignored.
  task automatic stray;
    if (!fast && $urandom_range(0, 3) == 0) mem_valid = 1'b1;
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int abort_beat);
    logic [31:0] a, base;
    logic [31:0] q[$];
    int          idx, guard;
    bit          hit;
    a    = {addr[31:2], 2'b00};
    base = a & ~32'hF;
    idx  = int'((a >> 4) % 16);
    hit  = res_v[idx] && (res_base[idx] == base);
    stall_cnt = 0;
    if (we) q.push_back(a);
    else if (!hit) for (int k = 0; k < 4; k++) q.push_back(base + 32'(4 * k));

    drive_phase;
    cpu_req = 1'b1; cpu_we = we; cpu_wdata = wd;
    cpu_addr = a | 32'($urandom_range(0, 3));
    @(negedge clk);
    if (stall_cache) stall_cnt++;
    if (!we && hit) begin
      chk("hit_stall", {31'd0, stall_cache}, 32'd0);
      chk("hit_rdata", cpu_rdata, memval(a));
      chk("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
      last_rdata = cpu_rdata;
      stray;
      return;
    end
    chk("first_stall", {31'd0, stall_cache}, 32'd1);
    chk("first_no_mem_req", {31'd0, mem_req}, 32'd0);
    stray;

    guard = 0;
    while (q.size() > 0) begin
      drive_phase;
      if (!fast && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'($urandom); cpu_we = 1'($urandom);
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      @(negedge clk);
      if (stall_cache) stall_cnt++;
      chk("beat_stall", {31'd0, stall_cache}, 32'd1);
      chk("beat_mem_req", {31'd0, mem_req}, 32'd1);
      chk("beat_mem_we", {31'd0, mem_we}, {31'd0, we});
      chk("beat_mem_addr", mem_addr, q[0]);
      if (we) chk("beat_mem_wdata", mem_wdata, wd);
      if (abort_beat >= 0 && (4 - q.size()) == abort_beat) begin
        mem_valid = 1'b1;
        mem_rdata = memval(q[0]);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        chk("abort_hold_stall", {31'd0, stall_cache}, 32'd0);
        cpu_req = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) res_v[i] = 1'b0;
        return;
      end
      guard++;
      if (guard > 64) begin
        total++; bad++;
        $display("FAIL beat_timeout: got %0d beats outstanding expected 0", q.size());
        return;
      end
      if (fast || $urandom_range(0, 2) != 0) begin
        mem_valid = 1'b1;
        if (we) mem_m[a] = wd;
        else    mem_rdata = memval(q[0]);
        void'(q.pop_front());
      end
    end

    drive_phase;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk);
    if (stall_cache) stall_cnt++;
    chk("final_stall", {31'd0, stall_cache}, 32'd0);
    chk("final_no_mem_req", {31'd0, mem_req}, 32'd0);
    if (!we) begin
      chk("final_rdata", cpu_rdata, memval(a));
      last_rdata = cpu_rdata;
      res_v[idx] = 1'b1;
      res_base[idx] = base;
    end
    stray;
  endtask

  task automatic idle_cycle;
    drive_phase;
    cpu_req = 1'b0;
    cpu_addr = $urandom;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall_cache}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    stray;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    fast = 1'b1;
    for (int i = 0; i < 16; i++) res_v[i] = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h100;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    cpu_req = 1'b0;
    rst_n = 1'b1;

    access(1'b0, 32'h100, 32'd0, -1);
    chk("t1_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("t1_rdata", last_rdata, 32'h0100FEFF);
    access(1'b0, 32'h10C, 32'd0, -1);
    chk("t2_stall_cycles", 32'(stall_cnt), 32'd0);
    chk("t2_rdata", last_rdata, 32'h010CFEF3);
    access(1'b1, 32'h104, 32'hDEADBEEF, -1);
    chk("t3_store_stall", 32'(stall_cnt), 32'd2);
    access(1'b0, 32'h104, 32'd0, -1);
    chk("t3_load_stall", 32'(stall_cnt), 32'd0);
    chk("t3_rdata", last_rdata, 32'hDEADBEEF);
    access(1'b1, 32'h2000, 32'h11111111, -1);
    chk("t4_store_stall", 32'(stall_cnt), 32'd2);
    access(1'b0, 32'h2000, 32'd0, -1);
    chk("t4_load_stall", 32'(stall_cnt), 32'd5);
    chk("t4_rdata", last_rdata, 32'h11111111);
    access(1'b0, 32'h100, 32'd0, -1);
    chk("t5_reload_stall", 32'(stall_cnt), 32'd5);
    access(1'b0, 32'h500, 32'd0, -1);
    chk("t5_conflict_stall", 32'(stall_cnt), 32'd5);
    chk("t5_rdata", last_rdata, 32'h0500FAFF);
    access(1'b0, 32'h100, 32'd0, -1);
    chk("t5_evicted_stall", 32'(stall_cnt), 32'd5);
    access(1'b0, 32'h300, 32'd0, 2);
    access(1'b0, 32'h300, 32'd0, -1);
    chk("t6_after_abort_stall", 32'(stall_cnt), 32'd5);

    fast = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle;
      else begin
        a = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 1)) << 8) |
            (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
        access($urandom_range(0, 9) < 3, a, $urandom, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
